// File: rtl/gardner_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : gardner_pkg                                                  |
// | Description : Shared types, defaults and helpers for the Gardner timing-   |
// |               error detector and its symbol-timing corrector.              |
// |               - state_t          one-hot FSM state encoding                |
// |               - HALF_CNT_DEFAULT mid-sample offset (half of 32 cycles)     |
// |               - sat_to_width()   signed saturation to an N-bit range       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package gardner_pkg;

   typedef enum logic [3:0] {
      S_IDLE = 4'b0001,
      S_MID  = 4'b0010,
      S_SYM  = 4'b0100,
      S_CALC = 4'b1000
   } state_t;

   localparam int HALF_CNT_DEFAULT = 16;

   // Clamp a signed value to the range of a w-bit two's complement word.
   // The result is returned in 64 bits; callers truncate with a size cast.
   // Valid for 2 <= w <= 63.
   function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] x,
                                                       input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (x > hi)
         return hi;
      else if (x < lo)
         return lo;
      else
         return x;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gardner_ted_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : gardner_ted_if                                               |
// | Description : Sample / error bundle between the timing corrector (master)  |
// |               and the Gardner timing-error detector (slave).               |
// |               I_32M, Q_32M  32.768M sample stream, signed                  |
// |               I_1M, Q_1M    on-time symbol, valid while strobe is high     |
// |               strobe        one-cycle on-time symbol pulse                 |
// |               error_n       negated filtered timing error, signed          |
// |               err_valid     one-cycle pulse when error_n updates           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface gardner_ted_if #(
   parameter int WIDTH = 16
);
   logic signed [WIDTH-1:0] I_32M;
   logic signed [WIDTH-1:0] Q_32M;
   logic signed [WIDTH-1:0] I_1M;
   logic signed [WIDTH-1:0] Q_1M;
   logic                    strobe;
   logic signed [WIDTH-1:0] error_n;
   logic                    err_valid;

   modport master (
      output I_32M, Q_32M, I_1M, Q_1M, strobe,
      input  error_n, err_valid
   );

   modport slave (
      input  I_32M, Q_32M, I_1M, Q_1M, strobe,
      output error_n, err_valid
   );
endinterface
`default_nettype wire

// File: rtl/gardner_loop_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gardner_loop_filter                                          |
// | Description : Loop filter for the Gardner timing loop.                     |
// |               GARDNER_TED_LOOP_FILTER_EN defined : PI filter with a        |
// |                 saturating (WIDTH+ACC_XTRA)-bit integrator updated on      |
// |                 e_valid; f = sat((e>>>KP_SHIFT) + acc_next).               |
// |               undefined : proportional only, f = e >>> KP_SHIFT.           |
// | Ports       : clk, rst_n        clock / async active-low reset             |
// |               e, e_valid        saturated Gardner error and its strobe     |
// |               KP_SHIFT/KI_SHIFT arithmetic right shifts (sampled at use)   |
// |               f                 filtered error (combinational)             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module gardner_loop_filter
   import gardner_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int ACC_XTRA = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [WIDTH-1:0] e,
   input  logic                    e_valid,
   input  logic [3:0]              KP_SHIFT,
   input  logic [3:0]              KI_SHIFT,
   output logic signed [WIDTH-1:0] f
);

`ifdef GARDNER_TED_LOOP_FILTER_EN
   localparam int ACC_W = WIDTH + ACC_XTRA;

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_nxt;

   // The output uses the already-updated integrator so the filtered value
   // and the integrator state advance together on the same error sample.
   always_comb begin
      acc_nxt = ACC_W'(sat_to_width(64'(acc) + 64'(e >>> KI_SHIFT), ACC_W));
      f       = WIDTH'(sat_to_width(64'(e >>> KP_SHIFT) + 64'(acc_nxt), WIDTH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= '0;
      else if (e_valid)
         acc <= acc_nxt;
   end
`else
   logic unused_cfg;

   assign f          = e >>> KP_SHIFT;
   assign unused_cfg = ^{clk, rst_n, e_valid, KI_SHIFT, 1'(ACC_XTRA)};
`endif

endmodule
`default_nettype wire

// File: rtl/gardner_ted.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gardner_ted                                                  |
// | Description : Gardner timing-error detector plus loop filter closing the   |
// |               symbol-timing loop around the 32.768M->1.024M corrector.     |
// |               Captures prev / mid / cur samples, forms                     |
// |               e = sat(((Imid*dI + Qmid*dQ) >>> (WIDTH-1))) once per        |
// |               symbol, filters it and drives error_n = sat(-f).             |
// |               err_valid pulses 2 cycles after the completing strobe.       |
// | Config      : GARDNER_TED_LOOP_FILTER_EN enables the PI integrator.        |
// | Ports       : clk, rst_n   32.768M clock, async active-low reset           |
// |               KP_SHIFT     proportional arithmetic right shift             |
// |               KI_SHIFT     integral arithmetic right shift                 |
// |               bus          gardner_ted_if.slave sample / error bundle      |
// | Limits      : WIDTH <= 31 (products are saturated through 64 bits).        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module gardner_ted
   import gardner_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int HALF_CNT = HALF_CNT_DEFAULT,
   parameter int ACC_XTRA = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  KP_SHIFT,
   input  logic [3:0]  KI_SHIFT,
   gardner_ted_if.slave bus
);

   localparam int CNT_W  = $clog2(HALF_CNT) + 1;
   localparam int PROD_W = 2 * WIDTH + 2;

   state_t state;
   state_t state_nxt;

   logic latch_prev;
   logic clr_cnt;
   logic cap_mid;
   logic cap_cur;

   logic [CNT_W-1:0]        cnt;
   logic signed [WIDTH-1:0] prev_i, prev_q;
   logic signed [WIDTH-1:0] mid_i, mid_q;
   // The current symbol is stored as its difference from the previous one,
   // because prev is overwritten by the same strobe that delivers cur.
   logic signed [WIDTH:0]   d_i, d_q;

   logic signed [PROD_W-1:0] e_full;
   logic signed [WIDTH-1:0]  e;
   logic                     e_valid;
   logic signed [WIDTH-1:0]  f;

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      latch_prev = 1'b0;
      clr_cnt    = 1'b0;
      cap_mid    = 1'b0;
      cap_cur    = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.strobe) begin
               latch_prev = 1'b1;
               clr_cnt    = 1'b1;
               state_nxt  = S_MID;
            end
         end
         // A strobe before the mid capture means the mid point was missed:
         // restart the symbol from this strobe (it also wins over a
         // coincident mid capture).
         S_MID, S_CALC: begin
            state_nxt = S_MID;
            if (bus.strobe) begin
               latch_prev = 1'b1;
               clr_cnt    = 1'b1;
            end else if (cnt == CNT_W'(HALF_CNT - 1)) begin
               cap_mid   = 1'b1;
               state_nxt = S_SYM;
            end
         end
         S_SYM: begin
            if (bus.strobe) begin
               cap_cur    = 1'b1;
               latch_prev = 1'b1;
               clr_cnt    = 1'b1;
               state_nxt  = S_CALC;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Counter and sample capture
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         prev_i <= '0;
         prev_q <= '0;
         mid_i  <= '0;
         mid_q  <= '0;
         d_i    <= '0;
         d_q    <= '0;
      end else begin
         // Saturating so that a long gap between strobes cannot wrap back
         // onto the mid-capture count.
         if (clr_cnt)
            cnt <= '0;
         else if (state != S_IDLE && !(&cnt))
            cnt <= cnt + 1'b1;

         if (cap_cur) begin
            d_i <= (WIDTH+1)'(prev_i) - (WIDTH+1)'(bus.I_1M);
            d_q <= (WIDTH+1)'(prev_q) - (WIDTH+1)'(bus.Q_1M);
         end
         if (latch_prev) begin
            prev_i <= bus.I_1M;
            prev_q <= bus.Q_1M;
         end
         if (cap_mid) begin
            mid_i <= bus.I_32M;
            mid_q <= bus.Q_32M;
         end
      end
   end

   // ------------------------------------------------------------------
   // Product stage (registered during S_CALC)
   // ------------------------------------------------------------------
   always_comb begin
      e_full = PROD_W'(mid_i) * PROD_W'(d_i) + PROD_W'(mid_q) * PROD_W'(d_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e       <= '0;
         e_valid <= 1'b0;
      end else begin
         e_valid <= (state == S_CALC);
         if (state == S_CALC)
            e <= WIDTH'(sat_to_width(64'(e_full >>> (WIDTH - 1)), WIDTH));
      end
   end

   // ------------------------------------------------------------------
   // Loop filter and negated output stage
   // ------------------------------------------------------------------
   gardner_loop_filter #(
      .WIDTH    (WIDTH),
      .ACC_XTRA (ACC_XTRA)
   ) u_loop_filter (
      .clk      (clk),
      .rst_n    (rst_n),
      .e        (e),
      .e_valid  (e_valid),
      .KP_SHIFT (KP_SHIFT),
      .KI_SHIFT (KI_SHIFT),
      .f        (f)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.error_n   <= '0;
         bus.err_valid <= 1'b0;
      end else begin
         bus.err_valid <= e_valid;
         if (e_valid)
            bus.error_n <= WIDTH'(sat_to_width(-(64'(f)), WIDTH));
      end
   end

endmodule
`default_nettype wire
